io_port_buffer: RTL and testbench
=================================

Name: io_port_buffer

Overview:
Buffers the CPU's I/O ports, sitting between external devices and the datapath's InPort and OutPort. On the input side, a device pushes words into a 4-deep FIFO with a valid/ready handshake, and the datapath pops one word per asserted InPortout edge (the "in Ra" T4 step). On the output side, a holding register captures the bus on OutPortin (the "out Ra" T3 step) and presents it to an external consumer with a valid/ready handshake. Error conditions set sticky flags.

Parameters:
WIDTH, 32, data word width
DEPTH, 4, input FIFO depth (power of two)
AW, 2, log2(DEPTH), pointer width

Ports:
clock  in  1  system clock, rising-edge active
clear  in  1  synchronous active-high reset
ext_in_data  in  WIDTH  device word to push
ext_in_valid  in  1  device offers ext_in_data
ext_in_ready  out  1  FIFO can accept (not full)
InPortdata  out  WIDTH  FIFO head word, driven to datapath InPort
InPortout  in  1  datapath consumes head (pop)
in_empty  out  1  FIFO holds zero words
in_count  out  AW+1  words held, 0..DEPTH
in_underflow  out  1  sticky: pop attempted while empty
BusMuxOut  in  WIDTH  datapath bus value
OutPortin  in  1  capture BusMuxOut into output register
ext_out_data  out  WIDTH  output register contents
ext_out_valid  out  1  ext_out_data not yet accepted
ext_out_ready  in  1  consumer accepts ext_out_data
out_overrun  out  1  sticky: unaccepted word overwritten

Behaviour:
- Clocking and reset
  - All state updates on the rising edge of clock.
  - clear is synchronous, active-high, and overrides every same-edge event.
  - Reset values: rd_ptr = wr_ptr = 0, in_count = 0, ext_out_data = 0, ext_out_valid = 0, in_underflow = 0, out_overrun = 0. FIFO storage is not cleared.
  - Mid-operation clear discards all buffered words and any pending output.
- Input FIFO
  - ext_in_ready = (in_count != DEPTH); in_empty = (in_count == 0). Both are combinational from registered count.
  - Push occurs on an edge where ext_in_valid && ext_in_ready: mem[wr_ptr] <= ext_in_data, wr_ptr++ mod DEPTH.
  - Pop occurs on an edge where InPortout && !in_empty: rd_ptr++ mod DEPTH.
  - Each edge with InPortout high pops once. The control step asserts InPortout for exactly one edge.
  - InPortdata = mem[rd_ptr] when non-empty, 0 when empty (combinational). The datapath samples it during the same cycle InPortout is high, so the word popped equals the word placed on the bus.
  - Push and pop on the same edge: both occur and count is unchanged.
  - When full, only the pop occurs; ready stays low that cycle.
  - When empty, the pop is ignored, the push occurs, and count becomes 1. The new word is not visible until the next cycle.
  - InPortout && in_empty sets in_underflow = 1 (sticky until clear).
  - Latency: a pushed word appears on InPortdata 1 edge after the push, if the FIFO was empty.
- Output register
  - On OutPortin: ext_out_data <= BusMuxOut and ext_out_valid <= 1. ext_out_data is then visible 1 edge later.
  - Handshake completes on an edge with ext_out_valid && ext_out_ready. On that edge, ext_out_valid <= 0 unless OutPortin is also high, in which case it stays 1 with the new data.
  - ext_out_data holds its last value after acceptance; it is never cleared except by clear.
  - OutPortin while ext_out_valid && !ext_out_ready: overwrite the data, keep valid = 1, and set out_overrun = 1 (sticky).
  - OutPortin on the same edge as acceptance is not an overrun.
- Input and output sides are fully independent.

Test Plan:
1. Reset then in R4 path: clear 1 cycle. Push 0x12345678, then assert InPortout 1 cycle at T4 -> InPortdata = 0x12345678 during the pop cycle, then in_empty = 1, in_count = 0, in_underflow = 0.
2. Fill/full: push 0x11, 0x22, 0x33, 0x44 back-to-back -> in_count = 4, ext_in_ready = 0. A 5th offer (0x55) is not accepted. Four single-cycle pops return 0x11, 0x22, 0x33, 0x44 in order.
3. Wrap plus simultaneous events: with 4 words loaded, push 0x55 and pop on the same edge. The edge is accepted only after ready rises, so first pop once, then push+pop together -> count stays 3. Draining returns 0x33, 0x44, 0x55 after the earlier pops, with pointers wrapped past 3 to 0.
4. Underflow: on an empty FIFO assert InPortout -> InPortdata = 0, count remains 0, in_underflow = 1. The flag holds until clear.
5. Out R4 path: BusMuxOut = 0x12345678 with OutPortin for 1 cycle -> next cycle ext_out_data = 0x12345678 and ext_out_valid = 1. Raise ext_out_ready for 1 cycle -> valid = 0 and data still 0x12345678. A second OutPortin (0xCAFEF00D) while valid && !ready sets out_overrun = 1 and the data becomes 0xCAFEF00D.
6. Mid-operation clear: 2 words in the FIFO and valid output pending, assert clear together with ext_in_valid and OutPortin -> all counts and flags go to 0, ext_out_data = 0, ext_out_valid = 0, and nothing is pushed or captured.

Source files
------------

// File: rtl/io_port_buffer.sv
// CPU I/O port buffer: 4-deep input FIFO feeding InPort, plus an output holding
// register that presents the OutPort word to an external consumer.
module io_port_buffer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] ext_in_data,
    input  logic             ext_in_valid,
    output logic             ext_in_ready,
    output logic [WIDTH-1:0] InPortdata,
    input  logic             InPortout,
    output logic             in_empty,
    output logic [AW:0]      in_count,
    output logic             in_underflow,
    input  logic [WIDTH-1:0] BusMuxOut,
    input  logic             OutPortin,
    output logic [WIDTH-1:0] ext_out_data,
    output logic             ext_out_valid,
    input  logic             ext_out_ready,
    output logic             out_overrun
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr, wr_ptr;
    logic             push, pop;

    assign ext_in_ready = (in_count != FULL);
    assign in_empty     = (in_count == '0);
    assign push         = ext_in_valid && ext_in_ready;
    assign pop          = InPortout && !in_empty;
    // Head word is forced to zero when empty so the bus never sees stale storage.
    assign InPortdata   = in_empty ? '0 : mem[rd_ptr];

    // Storage has no reset; clear only has to suppress a same-edge push.
    always_ff @(posedge clock) begin
        if (!clear && push)
            mem[wr_ptr] <= ext_in_data;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            in_count     <= '0;
            in_underflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                in_count <= in_count + 1'b1;
            else if (pop && !push)
                in_count <= in_count - 1'b1;
            if (InPortout && in_empty)
                in_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            ext_out_data  <= '0;
            ext_out_valid <= 1'b0;
            out_overrun   <= 1'b0;
        end else if (OutPortin) begin
            // A capture on the acceptance edge replaces an already-taken word: not an overrun.
            if (ext_out_valid && !ext_out_ready)
                out_overrun <= 1'b1;
            ext_out_data  <= BusMuxOut;
            ext_out_valid <= 1'b1;
        end else if (ext_out_valid && ext_out_ready) begin
            ext_out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_io_port_buffer.sv
// Bench for io_port_buffer: directed test-plan steps then random traffic, all
// compared each cycle against a queue-based reference model.
module tb_io_port_buffer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic             clock = 1'b0;
    logic             clear = 1'b1;
    logic [WIDTH-1:0] ext_in_data = '0;
    logic             ext_in_valid = 1'b0;
    logic             ext_in_ready;
    logic [WIDTH-1:0] InPortdata;
    logic             InPortout = 1'b0;
    logic             in_empty;
    logic [AW:0]      in_count;
    logic             in_underflow;
    logic [WIDTH-1:0] BusMuxOut = '0;
    logic             OutPortin = 1'b0;
    logic [WIDTH-1:0] ext_out_data;
    logic             ext_out_valid;
    logic             ext_out_ready = 1'b0;
    logic             out_overrun;

    io_port_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clock(clock), .clear(clear),
        .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .InPortdata(InPortdata), .InPortout(InPortout), .in_empty(in_empty),
        .in_count(in_count), .in_underflow(in_underflow),
        .BusMuxOut(BusMuxOut), .OutPortin(OutPortin),
        .ext_out_data(ext_out_data), .ext_out_valid(ext_out_valid),
        .ext_out_ready(ext_out_ready), .out_overrun(out_overrun)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Reference model: the FIFO is just a queue of words.
    logic [WIDTH-1:0] m_q[$];
    logic [WIDTH-1:0] m_out_data;
    bit               m_out_valid, m_und, m_ovr;
    bit               model_ok = 0;
    logic [WIDTH-1:0] pre_inport;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int n;
        n = m_q.size();
        chk("ready",     {31'd0, ext_in_ready}, {31'd0, n != DEPTH});
        chk("empty",     {31'd0, in_empty},     {31'd0, n == 0});
        chk("count",     {29'd0, in_count},     n);
        chk("inport",    InPortdata,            (n == 0) ? '0 : m_q[0]);
        chk("underflow", {31'd0, in_underflow}, {31'd0, m_und});
        chk("out_data",  ext_out_data,          m_out_data);
        chk("out_valid", {31'd0, ext_out_valid}, {31'd0, m_out_valid});
        chk("overrun",   {31'd0, out_overrun},  {31'd0, m_ovr});
    endtask

    task automatic model_edge();
        bit was_empty, was_full;
        if (clear) begin
            m_q.delete();
            m_out_data = '0; m_out_valid = 0; m_und = 0; m_ovr = 0;
            model_ok = 1;
            return;
        end
        was_empty = (m_q.size() == 0);
        was_full  = (m_q.size() == DEPTH);
        if (InPortout && was_empty) m_und = 1;
        if (InPortout && !was_empty) void'(m_q.pop_front());
        if (ext_in_valid && !was_full) m_q.push_back(ext_in_data);
        if (OutPortin) begin
            if (m_out_valid && !ext_out_ready) m_ovr = 1;
            m_out_data = BusMuxOut;
            m_out_valid = 1;
        end else if (m_out_valid && ext_out_ready) begin
            m_out_valid = 0;
        end
    endtask

    // One clock: drive at negedge, check pre-edge outputs, update model on the edge.
    task automatic cycle(input logic clr, input logic iv, input logic [WIDTH-1:0] id,
                         input logic pop, input logic [WIDTH-1:0] bus,
                         input logic oin, input logic ordy);
        @(negedge clock);
        clear = clr; ext_in_valid = iv; ext_in_data = id; InPortout = pop;
        BusMuxOut = bus; OutPortin = oin; ext_out_ready = ordy;
        #1;
        if (model_ok) check_model();
        pre_inport = InPortdata;
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] d);
        cycle(0, 1, d, 0, '0, 0, 0);
    endtask

    task automatic popc();
        cycle(0, 0, '0, 1, '0, 0, 0);
    endtask

    task automatic idle();
        cycle(0, 0, '0, 0, '0, 0, 0);
    endtask

    initial begin
        // 1: reset, then push/pop one word
        cycle(1, 0, '0, 0, '0, 0, 0);
        chk("rst_count", {29'd0, in_count}, 0);
        chk("rst_valid", {31'd0, ext_out_valid}, 0);
        chk("rst_out_data", ext_out_data, 0);
        push(32'h12345678);
        chk("t1_visible", InPortdata, 32'h12345678);
        popc();
        chk("t1_pop_data", pre_inport, 32'h12345678);
        chk("t1_empty", {31'd0, in_empty}, 1);
        chk("t1_no_underflow", {31'd0, in_underflow}, 0);

        // 2: fill, refuse a fifth word, drain in order
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        chk("t2_count", {29'd0, in_count}, 4);
        chk("t2_ready", {31'd0, ext_in_ready}, 0);
        push(32'h55);
        chk("t2_still_full", {29'd0, in_count}, 4);
        popc(); chk("t2_pop0", pre_inport, 32'h11);
        popc(); chk("t2_pop1", pre_inport, 32'h22);
        popc(); chk("t2_pop2", pre_inport, 32'h33);
        popc(); chk("t2_pop3", pre_inport, 32'h44);
        chk("t2_empty", {31'd0, in_empty}, 1);

        // 3: simultaneous push+pop after a single pop from full
        push(32'h11); push(32'h22); push(32'h33); push(32'h44);
        popc(); chk("t3_pop_a", pre_inport, 32'h11);
        cycle(0, 1, 32'h55, 1, '0, 0, 0);
        chk("t3_pp_data", pre_inport, 32'h22);
        chk("t3_count", {29'd0, in_count}, 3);
        popc(); chk("t3_d0", pre_inport, 32'h33);
        popc(); chk("t3_d1", pre_inport, 32'h44);
        popc(); chk("t3_d2", pre_inport, 32'h55);

        // 4: underflow is sticky
        popc();
        chk("t4_inport_zero", pre_inport, 0);
        chk("t4_underflow", {31'd0, in_underflow}, 1);
        chk("t4_count", {29'd0, in_count}, 0);
        idle(); idle();
        chk("t4_sticky", {31'd0, in_underflow}, 1);

        // 5: output register capture, accept, overrun
        cycle(0, 0, '0, 0, 32'h12345678, 1, 0);
        chk("t5_data", ext_out_data, 32'h12345678);
        chk("t5_valid", {31'd0, ext_out_valid}, 1);
        cycle(0, 0, '0, 0, '0, 0, 1);
        chk("t5_accepted", {31'd0, ext_out_valid}, 0);
        chk("t5_hold", ext_out_data, 32'h12345678);
        cycle(0, 0, '0, 0, 32'h0BADBEEF, 1, 0);
        cycle(0, 0, '0, 0, 32'hCAFEF00D, 1, 0);
        chk("t5_overrun", {31'd0, out_overrun}, 1);
        chk("t5_new_data", ext_out_data, 32'hCAFEF00D);
        // capture on the acceptance edge is not an overrun (checked after a clear)
        cycle(1, 0, '0, 0, '0, 0, 0);
        cycle(0, 0, '0, 0, 32'hA5A5A5A5, 1, 0);
        cycle(0, 0, '0, 0, 32'h5A5A5A5A, 1, 1);
        chk("t5_no_overrun", {31'd0, out_overrun}, 0);
        chk("t5_replace", ext_out_data, 32'h5A5A5A5A);

        // 6: clear mid-operation beats same-edge push and capture
        push(32'hAA); push(32'hBB);
        cycle(0, 0, '0, 0, 32'hDEAD0001, 1, 0);
        cycle(1, 1, 32'hCC, 0, 32'hDEAD0002, 1, 0);
        chk("t6_count", {29'd0, in_count}, 0);
        chk("t6_valid", {31'd0, ext_out_valid}, 0);
        chk("t6_data", ext_out_data, 0);
        chk("t6_overrun", {31'd0, out_overrun}, 0);
        idle();

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0), $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 2) == 0, $urandom,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
